// File: rtl/pc_fetch_unit.sv
// Program counter and next-PC selection for the single-cycle datapath, with a BOOT/RUN/TRAP sequencer.
// Optional performance counters are built when PC_FETCH_PERF_CNT_EN is defined.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC         = 32'h0000_0000,
  parameter bit          TRAP_ON_MISALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        imem_valid,
  input  logic        branch,
  input  logic        branch2,
  input  logic        branch3,
  input  logic        jump,
  input  logic        jumpreg,
  input  logic        alu_zero,
  input  logic        alu_neg,
  input  logic [31:0] imm_ext,
  input  logic [25:0] jtarget,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_req,
  output logic        br_taken,
  output logic        trap,
  output logic [31:0] retired_cnt,
  output logic [31:0] taken_cnt
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_TRAP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] br_target, j_target, jr_target, next_pc;
  logic        advance, misaligned, enter_trap;

  always_comb begin
    br_taken = 1'b0;
    unique case ({branch, branch2, branch3})
      3'b100:  br_taken = alu_zero;
      3'b110:  br_taken = ~alu_neg;
      3'b010:  br_taken = ~alu_neg & ~alu_zero;
      3'b101:  br_taken = alu_neg | alu_zero;
      3'b001:  br_taken = alu_neg;
      3'b111:  br_taken = ~alu_zero;
      default: br_taken = 1'b0;
    endcase
  end

  assign pc_plus4   = pc_q + 32'd4;
  assign br_target  = pc_plus4 + (imm_ext << 2);
  assign j_target   = {pc_plus4[31:28], jtarget, 2'b00};
  assign misaligned = (rs_data[1:0] != 2'b00);
  assign jr_target  = TRAP_ON_MISALIGN ? rs_data : {rs_data[31:2], 2'b00};

  always_comb begin
    if (jumpreg)       next_pc = jr_target;
    else if (jump)     next_pc = j_target;
    else if (br_taken) next_pc = br_target;
    else               next_pc = pc_plus4;
  end

  assign advance    = (state_q == ST_RUN) & imem_valid & ~stall;
  // A misaligned jr freezes the PC at the offending instruction instead of jumping.
  assign enter_trap = advance & jumpreg & misaligned & TRAP_ON_MISALIGN;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (enter_trap)   state_d = ST_TRAP;
        else if (advance) pc_d    = next_pc;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign pc        = pc_q;
  assign fetch_req = (state_q == ST_RUN);
  assign trap      = (state_q == ST_TRAP);

`ifdef PC_FETCH_PERF_CNT_EN
  logic [31:0] retired_q, taken_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= 32'h0;
      taken_q   <= 32'h0;
    end else if (advance) begin
      retired_q <= retired_q + 32'd1;
      if (br_taken | jump | jumpreg) taken_q <= taken_q + 32'd1;
    end
  end

  assign retired_cnt = retired_q;
  assign taken_cnt   = taken_q;
`else
  assign retired_cnt = 32'h0;
  assign taken_cnt   = 32'h0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: two instances (trap on / force-align) driven by shared stimulus,
// checked against a next-PC reference model.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, stall, imem_valid, branch, branch2, branch3, jump, jumpreg;
  logic        alu_zero, alu_neg;
  logic [31:0] imm_ext, rs_data;
  logic [25:0] jtarget;

  logic [31:0] pc_w [2];
  logic [31:0] pc4_w [2];
  logic [31:0] ret_w [2];
  logic [31:0] tkn_w [2];
  logic        fetch_w [2];
  logic        brt_w [2];
  logic        trap_w [2];

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: 0 = boot, 1 = run, 2 = trap
  int          m_st  [2];
  logic [31:0] m_pc  [2];
  logic [31:0] m_ret [2];
  logic [31:0] m_tk  [2];
  bit          m_trapmode [2];

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_PC(32'h0000_0040), .TRAP_ON_MISALIGN(1'b1)) dut_a (
    .clk(clk), .reset(reset), .stall(stall), .imem_valid(imem_valid),
    .branch(branch), .branch2(branch2), .branch3(branch3), .jump(jump), .jumpreg(jumpreg),
    .alu_zero(alu_zero), .alu_neg(alu_neg), .imm_ext(imm_ext), .jtarget(jtarget),
    .rs_data(rs_data), .pc(pc_w[0]), .pc_plus4(pc4_w[0]), .fetch_req(fetch_w[0]),
    .br_taken(brt_w[0]), .trap(trap_w[0]), .retired_cnt(ret_w[0]), .taken_cnt(tkn_w[0]));

  pc_fetch_unit #(.RESET_PC(32'h0000_0040), .TRAP_ON_MISALIGN(1'b0)) dut_b (
    .clk(clk), .reset(reset), .stall(stall), .imem_valid(imem_valid),
    .branch(branch), .branch2(branch2), .branch3(branch3), .jump(jump), .jumpreg(jumpreg),
    .alu_zero(alu_zero), .alu_neg(alu_neg), .imm_ext(imm_ext), .jtarget(jtarget),
    .rs_data(rs_data), .pc(pc_w[1]), .pc_plus4(pc4_w[1]), .fetch_req(fetch_w[1]),
    .br_taken(brt_w[1]), .trap(trap_w[1]), .retired_cnt(ret_w[1]), .taken_cnt(tkn_w[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_taken(input logic [2:0] code, input bit z, input bit n);
    case (code)
      3'b100:  return z;
      3'b110:  return !n;
      3'b010:  return !n && !z;
      3'b101:  return n || z;
      3'b001:  return n;
      3'b111:  return !z;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_next(input int d, input logic [31:0] cur);
    logic [31:0] p4;
    p4 = cur + 32'd4;
    if (jumpreg)
      return m_trapmode[d] ? rs_data : (rs_data & 32'hFFFF_FFFC);
    if (jump)
      return {p4[31:28], jtarget, 2'b00};
    if (model_taken({branch, branch2, branch3}, alu_zero, alu_neg))
      return p4 + imm_ext * 32'd4;
    return p4;
  endfunction

  function automatic logic [31:0] exp_cnt(input logic [31:0] v);
`ifdef PC_FETCH_PERF_CNT_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  task automatic set_idle();
    stall = 1'b0; imem_valid = 1'b1;
    branch = 1'b0; branch2 = 1'b0; branch3 = 1'b0;
    jump = 1'b0; jumpreg = 1'b0; alu_zero = 1'b0; alu_neg = 1'b0;
    imm_ext = 32'h0; jtarget = 26'h0; rs_data = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      m_st[d] = 0; m_pc[d] = 32'h40; m_ret[d] = 32'h0; m_tk[d] = 32'h0;
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Compare all outputs against the model for the current inputs, then clock once.
  task automatic cycle();
    bit tk, adv;
    #1;
    tk = model_taken({branch, branch2, branch3}, alu_zero, alu_neg);
    for (int d = 0; d < 2; d++) begin
      check("pc", pc_w[d], m_pc[d]);
      check("pc_plus4", pc4_w[d], m_pc[d] + 32'd4);
      check("br_taken", {31'h0, brt_w[d]}, {31'h0, tk});
      check("fetch_req", {31'h0, fetch_w[d]}, {31'h0, m_st[d] == 1});
      check("trap", {31'h0, trap_w[d]}, {31'h0, m_st[d] == 2});
      check("retired_cnt", ret_w[d], exp_cnt(m_ret[d]));
      check("taken_cnt", tkn_w[d], exp_cnt(m_tk[d]));
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      adv = (m_st[d] == 1) && imem_valid && !stall;
      if (m_st[d] == 0) m_st[d] = 1;
      else if (adv) begin
        m_ret[d]++;
        if (tk || jump || jumpreg) m_tk[d]++;
        if (jumpreg && rs_data[1:0] != 2'b00 && m_trapmode[d]) m_st[d] = 2;
        else m_pc[d] = model_next(d, m_pc[d]);
      end
    end
    @(negedge clk);
  endtask

  task automatic jr_to(input logic [31:0] tgt);
    set_idle();
    jumpreg = 1'b1; rs_data = tgt;
    cycle();
    set_idle();
  endtask

  initial begin
    m_trapmode[0] = 1'b1;
    m_trapmode[1] = 1'b0;
    set_idle();
    reset = 1'b1;
    @(negedge clk);
    do_reset();

    // Boot cycle, then sequential fetch
    check("boot_pc", pc_w[0], 32'h40);
    check("boot_fetch_req", {31'h0, fetch_w[0]}, 32'h0);
    cycle();
    check("run_pc0", pc_w[0], 32'h40);
    cycle();
    check("run_pc1", pc_w[0], 32'h44);
    cycle();
    check("run_pc2", pc_w[0], 32'h48);

    // Backward BEQ taken / not taken
    jr_to(32'h100);
    branch = 1'b1; alu_zero = 1'b1; imm_ext = 32'hFFFF_FFFE;
    cycle();
    check("beq_taken_pc", pc_w[0], 32'hFC);
    jr_to(32'h100);
    branch = 1'b1; alu_zero = 1'b0; imm_ext = 32'hFFFF_FFFE;
    cycle();
    check("beq_not_taken_pc", pc_w[0], 32'h104);

    // Branch-condition sweep with PC held
    for (int c = 0; c < 8; c++)
      for (int f = 0; f < 4; f++) begin
        set_idle();
        stall = 1'b1;
        {branch, branch2, branch3} = c[2:0];
        {alu_zero, alu_neg} = f[1:0];
        cycle();
      end

    // Jump beats branch; register jump
    jr_to(32'h1000_0000);
    jump = 1'b1; jtarget = 26'h0000010; branch = 1'b1; alu_zero = 1'b1; imm_ext = 32'h8;
    cycle();
    check("jump_over_branch", pc_w[0], 32'h1000_0040);
    jr_to(32'h200);
    check("jr_pc", pc_w[0], 32'h200);

    // Misaligned jr: instance A traps, instance B force-aligns
    jr_to(32'h203);
    check("trap_set", {31'h0, trap_w[0]}, 32'h1);
    check("trap_pc_held", pc_w[0], 32'h200);
    check("trap_fetch_req", {31'h0, fetch_w[0]}, 32'h0);
    check("align_pc", pc_w[1], 32'h200);
    for (int i = 0; i < 4; i++) begin
      jump = 1'b1; jtarget = 26'($urandom);
      cycle();
    end
    check("trap_sticky", {31'h0, trap_w[0]}, 32'h1);

    // Stall / invalid hold, then counted advances
    set_idle();
    do_reset();
    cycle();
    stall = 1'b1;
    repeat (3) cycle();
    stall = 1'b0; imem_valid = 1'b0;
    repeat (2) cycle();
    check("hold_pc", pc_w[0], 32'h40);
    check("hold_retired", ret_w[0], 32'h0);
    for (int i = 0; i < 5; i++) begin
      set_idle();
      if (i == 1 || i == 3) begin branch = 1'b1; alu_zero = 1'b1; imm_ext = 32'h1; end
      cycle();
    end
    check("retired_5", ret_w[0], exp_cnt(32'd5));
    check("taken_2", tkn_w[0], exp_cnt(32'd2));

    // PC wrap-around
    jr_to(32'hFFFF_FFFC);
    cycle();
    check("wrap_pc", pc_w[0], 32'h0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        set_idle();
        do_reset();
      end
      stall      = ($urandom_range(0, 3) == 0);
      imem_valid = ($urandom_range(0, 3) != 0);
      {branch, branch2, branch3} = 3'($urandom);
      jump       = ($urandom_range(0, 7) == 0);
      jumpreg    = ($urandom_range(0, 7) == 0);
      alu_zero   = 1'($urandom);
      alu_neg    = 1'($urandom);
      imm_ext    = (32'($urandom) & 32'h8000_FFFF);
      if (imm_ext[31]) imm_ext = imm_ext | 32'hFFFF_0000;
      jtarget    = 26'($urandom);
      rs_data    = 32'($urandom);
      if ($urandom_range(0, 7) != 0) rs_data[1:0] = 2'b00;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
